hit_turn_ctrl: RTL and testbench
================================

HIT_TURN_CTRL -- requirements
Module: hit_turn_ctrl

Interface
REQ-001 Parameter MAX_HP, default 5: starting hit points per player (1..15).
REQ-002 Parameter COOLDOWN_TICKS, default 32_500_000: post-shot lockout length in clk cycles (0.5 s at 65 MHz); matches the sprite flash window.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a new game.
REQ-006 shot_done  input  1  one-cycle pulse; active player's projectile has landed or left the screen.
REQ-007 hit_cat_in  input  1  one-cycle collision pulse, projectile vs cat sprite.
REQ-008 hit_dog_in  input  1  one-cycle collision pulse, projectile vs dog sprite.
REQ-009 hit_cat  output  1  one-cycle pulse to the cat draw block's flash trigger.
REQ-010 hit_dog  output  1  one-cycle pulse to the dog draw block's flash trigger.
REQ-011 hp_cat  output  4  cat hit points.
REQ-012 hp_dog  output  4  dog hit points.
REQ-013 turn_dog  output  1  1 = dog may shoot, 0 = cat may shoot; valid only when shoot_en = 1.
REQ-014 shoot_en  output  1  high only in TURN; launcher accepts fire only while high.
REQ-015 game_state  output  2  current FSM state code.
REQ-016 winner  output  2  00 none, 01 cat, 10 dog, 11 draw.

Function
REQ-017 FSM states: IDLE, TURN, COOLDOWN, OVER; all outputs registered.
REQ-018 IDLE: start -> TURN; same edge hp_cat = hp_dog = MAX_HP, turn_dog = 0 (cat first), winner = 00.
REQ-019 TURN: hit_cat_in -> hp_cat decrements by 1 (saturating at 0), hit_cat pulses one cycle later, state -> COOLDOWN; dog side symmetric.
REQ-020 TURN: hit_cat_in and hit_dog_in together -> both hp decrement, both hit pulses assert in the same cycle, single COOLDOWN entry.
REQ-021 TURN: shot_done with no hit -> COOLDOWN, no hp change, no hit pulse; shot_done together with a hit -> hit handling of REQ-019/020, counted once.
REQ-022 Hit output latency: exactly 1 cycle from sampled input to pulse; pulse width exactly 1 cycle.
REQ-023 Self-hit (shooter hits itself) is processed identically to an opponent hit.
REQ-024 COOLDOWN: counter runs from 0; hit_*_in, shot_done and start are ignored; after COOLDOWN_TICKS cycles in COOLDOWN the FSM leaves.
REQ-025 COOLDOWN exit: either hp = 0 -> OVER; otherwise turn_dog toggles and state -> TURN on the same edge.
REQ-026 OVER entry: winner = 01 if hp_dog = 0 and hp_cat > 0; 10 if hp_cat = 0 and hp_dog > 0; 11 if both are 0.
REQ-027 OVER: hit inputs and shot_done are ignored; start -> TURN with the REQ-018 reload. winner clears to 00 on that edge.
REQ-028 start in TURN or COOLDOWN is ignored; no mid-game restart.
REQ-029 Cooldown counter width is $clog2(COOLDOWN_TICKS+1); counter holds at 0 outside COOLDOWN.

Reset
REQ-030 rst (synchronous) forces: state IDLE, hp_cat = hp_dog = MAX_HP, turn_dog = 0, shoot_en = 0, hit_cat = hit_dog = 0, winner = 00, counter = 0.
REQ-031 rst asserted mid-COOLDOWN or in OVER aborts immediately; any pending hit pulse is dropped.
REQ-032 rst has priority over every other input on the same edge.

Structure
REQ-033 State enum, winner codes and the default MAX_HP/COOLDOWN_TICKS values reside in shared package game_pkg.
REQ-034 The lockout counter is sub-module cooldown_timer (inputs load, enable; output done), instantiated once.
REQ-035 hit_cat/hit_dog connect directly to the hit inputs of the cat and dog draw blocks; those blocks' own flash timers are not modified.

Verification (bench: MAX_HP = 2, COOLDOWN_TICKS = 4)
REQ-036 rst, start -> hp_cat = hp_dog = 2, turn_dog = 0, shoot_en = 1 on the next cycle.
REQ-037 TURN, hit_dog_in pulse -> hit_dog high exactly 1 cycle later; hp_dog = 1; shoot_en low for 4 cycles; then turn_dog = 1.
REQ-038 TURN, shot_done only -> no hit pulse, hp unchanged, turn toggles after 4 cycles.
REQ-039 hp_cat = hp_dog = 1; simultaneous hit_cat_in and hit_dog_in -> both pulses in the same cycle, hp = 0/0, OVER with winner = 11.
REQ-040 hit_cat_in during COOLDOWN -> ignored, hp_cat unchanged; rst mid-COOLDOWN -> IDLE with hp = 2/2 on the next cycle.
REQ-041 OVER with winner = 10, start -> TURN, hp = 2/2, winner = 00, turn_dog = 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the turn-based hit/turn controller.
// Holds the FSM state encoding, the winner codes, the default game
// parameters and a couple of small helper functions shared by the RTL.
package game_pkg;

  // Values are exported on game_state, so the encoding is fixed.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TURN     = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_OVER     = 2'd3
  } game_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_CAT  = 2'b01;
  localparam logic [1:0] WIN_DOG  = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int DEF_MAX_HP         = 5;
  // 0.5 s at 65 MHz, lined up with the sprite flash window.
  localparam int DEF_COOLDOWN_TICKS = 32_500_000;

  // Saturating hit-point decrement.
  function automatic logic [3:0] hp_dec(input logic [3:0] hp);
    return (hp == 4'd0) ? 4'd0 : hp - 4'd1;
  endfunction

  // Winner code from the final hit points; WIN_NONE while both are alive.
  function automatic logic [1:0] winner_code(input logic [3:0] hp_cat,
                                             input logic [3:0] hp_dog);
    if (hp_cat == 4'd0 && hp_dog == 4'd0) return WIN_DRAW;
    if (hp_dog == 4'd0)                   return WIN_CAT;
    if (hp_cat == 4'd0)                   return WIN_DOG;
    return WIN_NONE;
  endfunction

endpackage

// File: rtl/cooldown_timer.sv
// Post-shot lockout counter.
// Counts cycles while enable is high and flags done during the last cycle
// of a TICKS-cycle window, so a controller reacting to done leaves the
// lockout after exactly TICKS cycles. The count sits at zero whenever the
// timer is not enabled.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset
//   load   - restart the count from zero
//   enable - high while the controller is in its lockout state
//   done   - combinational, high in the final lockout cycle
module cooldown_timer #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic done
);

  localparam int CW     = (TICKS < 1) ? 1 : $clog2(TICKS + 1);
  // A zero-length lockout still needs one cycle in the lockout state.
  localparam int LAST_I = (TICKS < 1) ? 0 : TICKS - 1;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);

  logic [CW-1:0] count;

  assign done = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || load || done || !enable) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hit_turn_ctrl.sv
// Game flow controller for the cat-vs-dog artillery game.
// Tracks hit points, whose turn it is, the post-shot lockout and the
// winner. All outputs are registered; hit_cat/hit_dog are one-cycle
// pulses that drive the draw blocks' flash triggers directly.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   start                 - pulse, starts a game from IDLE or OVER
//   shot_done             - pulse, projectile landed/left screen
//   hit_cat_in/hit_dog_in - collision pulses from the sprite checker
//   hit_cat/hit_dog       - flash trigger pulses, one cycle after a hit
//   hp_cat/hp_dog         - remaining hit points
//   turn_dog              - 1 = dog's turn, 0 = cat's turn
//   shoot_en              - launcher may fire (TURN only)
//   game_state            - current state code
//   winner                - 00 none, 01 cat, 10 dog, 11 draw
module hit_turn_ctrl
  import game_pkg::*;
#(
  parameter int MAX_HP         = DEF_MAX_HP,
  parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       shot_done,
  input  logic       hit_cat_in,
  input  logic       hit_dog_in,
  output logic       hit_cat,
  output logic       hit_dog,
  output logic [3:0] hp_cat,
  output logic [3:0] hp_dog,
  output logic       turn_dog,
  output logic       shoot_en,
  output logic [1:0] game_state,
  output logic [1:0] winner
);

  localparam logic [3:0] HP_INIT = 4'(MAX_HP);

  game_state_t state;
  logic        shot_end;
  logic        cd_load;
  logic        cd_enable;
  logic        cd_done;

  // A hit ends the turn on its own, so shot_done alongside it adds nothing.
  assign shot_end   = hit_cat_in || hit_dog_in || shot_done;
  assign cd_load    = (state == ST_TURN) && shot_end;
  assign cd_enable  = (state == ST_COOLDOWN);
  assign game_state = state;

  cooldown_timer #(
    .TICKS (COOLDOWN_TICKS)
  ) u_cooldown (
    .clk    (clk),
    .rst    (rst),
    .load   (cd_load),
    .enable (cd_enable),
    .done   (cd_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hp_cat   <= HP_INIT;
      hp_dog   <= HP_INIT;
      turn_dog <= 1'b0;
      shoot_en <= 1'b0;
      hit_cat  <= 1'b0;
      hit_dog  <= 1'b0;
      winner   <= WIN_NONE;
    end else begin
      hit_cat <= 1'b0;
      hit_dog <= 1'b0;
      case (state)
        // IDLE and OVER both wait for start and reload a fresh game.
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state    <= ST_TURN;
            hp_cat   <= HP_INIT;
            hp_dog   <= HP_INIT;
            turn_dog <= 1'b0;
            shoot_en <= 1'b1;
            winner   <= WIN_NONE;
          end
        end
        // Self-hits need no special case: the hit input alone decides
        // which side loses a point, regardless of whose turn it is.
        ST_TURN: begin
          if (hit_cat_in) begin
            hp_cat  <= hp_dec(hp_cat);
            hit_cat <= 1'b1;
          end
          if (hit_dog_in) begin
            hp_dog  <= hp_dec(hp_dog);
            hit_dog <= 1'b1;
          end
          if (shot_end) begin
            state    <= ST_COOLDOWN;
            shoot_en <= 1'b0;
          end
        end
        // Inputs are deliberately ignored during the lockout.
        ST_COOLDOWN: begin
          if (cd_done) begin
            if (hp_cat == 4'd0 || hp_dog == 4'd0) begin
              state  <= ST_OVER;
              winner <= winner_code(hp_cat, hp_dog);
            end else begin
              state    <= ST_TURN;
              turn_dog <= ~turn_dog;
              shoot_en <= 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          shoot_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hit_turn_ctrl.sv
// Self-checking bench for hit_turn_ctrl with MAX_HP = 2, COOLDOWN_TICKS = 4.
// Directed scenario tasks check against hand-derived constants; a random
// phase compares every cycle against a behavioural game model.
module tb_hit_turn_ctrl;

  localparam int MAX_HP = 2;
  localparam int TICKS  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       shot_done = 1'b0;
  logic       hit_cat_in = 1'b0;
  logic       hit_dog_in = 1'b0;
  logic       hit_cat;
  logic       hit_dog;
  logic [3:0] hp_cat;
  logic [3:0] hp_dog;
  logic       turn_dog;
  logic       shoot_en;
  logic [1:0] game_state;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  hit_turn_ctrl #(
    .MAX_HP         (MAX_HP),
    .COOLDOWN_TICKS (TICKS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .shot_done  (shot_done),
    .hit_cat_in (hit_cat_in),
    .hit_dog_in (hit_dog_in),
    .hit_cat    (hit_cat),
    .hit_dog    (hit_dog),
    .hp_cat     (hp_cat),
    .hp_dog     (hp_dog),
    .turn_dog   (turn_dog),
    .shoot_en   (shoot_en),
    .game_state (game_state),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  // Behavioural game model: phase 0 idle, 1 turn, 2 lockout, 3 over.
  int m_phase = 0;
  int m_hpc   = MAX_HP;
  int m_hpd   = MAX_HP;
  int m_turn  = 0;
  int m_left  = 0;
  int m_fc    = 0;
  int m_fd    = 0;
  int m_win   = 0;

  task automatic model_new_game();
    m_phase = 1; m_hpc = MAX_HP; m_hpd = MAX_HP; m_turn = 0; m_win = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit sd,
                            input bit hc, input bit hd);
    m_fc = 0;
    m_fd = 0;
    if (r) begin
      m_phase = 0; m_hpc = MAX_HP; m_hpd = MAX_HP;
      m_turn = 0; m_win = 0; m_left = 0;
    end else if (m_phase == 0 || m_phase == 3) begin
      if (s) model_new_game();
    end else if (m_phase == 1) begin
      if (hc) begin m_hpc = (m_hpc > 0) ? m_hpc - 1 : 0; m_fc = 1; end
      if (hd) begin m_hpd = (m_hpd > 0) ? m_hpd - 1 : 0; m_fd = 1; end
      if (hc || hd || sd) begin m_phase = 2; m_left = TICKS; end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_hpc == 0 || m_hpd == 0) begin
          m_phase = 3;
          m_win = (m_hpc == 0 && m_hpd == 0) ? 3 : (m_hpd == 0) ? 1 : 2;
        end else begin
          m_phase = 1;
          m_turn  = 1 - m_turn;
        end
      end
    end
  endtask

  function automatic logic [15:0] pack(input int st, input int pc, input int pd,
                                       input int tn, input int se, input int fc,
                                       input int fd, input int wn);
    logic [1:0] st2, wn2;
    logic [3:0] pc4, pd4;
    st2 = st[1:0]; pc4 = pc[3:0]; pd4 = pd[3:0]; wn2 = wn[1:0];
    return {st2, pc4, pd4, tn[0], se[0], fc[0], fd[0], wn2};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {game_state, hp_cat, hp_dog, turn_dog, shoot_en, hit_cat, hit_dog, winner};
  endfunction

  // Applies one cycle of inputs, advances the model, samples 1 ns after the edge.
  task automatic tick(input bit r, input bit s, input bit sd, input bit hc, input bit hd);
    rst = r; start = s; shot_done = sd; hit_cat_in = hc; hit_dog_in = hd;
    @(posedge clk);
    model_step(r, s, sd, hc, hd);
    #1;
    rst = 1'b0; start = 1'b0; shot_done = 1'b0; hit_cat_in = 1'b0; hit_dog_in = 1'b0;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 1, 1, 1);
    checks++;
    if (dut_vec() !== pack(0, 2, 2, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", dut_vec(), pack(0, 2, 2, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_start();
    tick(0, 1, 0, 0, 0);
    checks++;
    if (dut_vec() !== pack(1, 2, 2, 0, 1, 0, 0, 0)) begin
      errors++;
      $display("FAIL start_reload: got %h expected %h", dut_vec(), pack(1, 2, 2, 0, 1, 0, 0, 0));
    end
  endtask

  task automatic test_hit_dog();
    tick(0, 0, 0, 0, 1);
    checks++;
    if (dut_vec() !== pack(2, 2, 1, 0, 0, 0, 1, 0)) begin
      errors++;
      $display("FAIL hit_dog_pulse: got %h expected %h", dut_vec(), pack(2, 2, 1, 0, 0, 0, 1, 0));
    end
    for (int i = 0; i < TICKS - 1; i++) begin
      tick(0, 0, 0, 0, 0);
      checks++;
      if (dut_vec() !== pack(2, 2, 1, 0, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL hit_dog_lockout[%0d]: got %h expected %h", i, dut_vec(), pack(2, 2, 1, 0, 0, 0, 0, 0));
      end
    end
    tick(0, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== pack(1, 2, 1, 1, 1, 0, 0, 0)) begin
      errors++;
      $display("FAIL hit_dog_turn_swap: got %h expected %h", dut_vec(), pack(1, 2, 1, 1, 1, 0, 0, 0));
    end
  endtask

  task automatic test_shot_done();
    tick(0, 0, 1, 0, 0);
    checks++;
    if (dut_vec() !== pack(2, 2, 1, 1, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL miss_enter: got %h expected %h", dut_vec(), pack(2, 2, 1, 1, 0, 0, 0, 0));
    end
    for (int i = 0; i < TICKS - 1; i++) tick(0, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== pack(2, 2, 1, 1, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL miss_lockout_end: got %h expected %h", dut_vec(), pack(2, 2, 1, 1, 0, 0, 0, 0));
    end
    tick(0, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== pack(1, 2, 1, 0, 1, 0, 0, 0)) begin
      errors++;
      $display("FAIL miss_turn_swap: got %h expected %h", dut_vec(), pack(1, 2, 1, 0, 1, 0, 0, 0));
    end
  endtask

  task automatic test_cooldown_ignore_and_reset();
    tick(0, 0, 0, 1, 0);
    checks++;
    if (dut_vec() !== pack(2, 1, 1, 0, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL cd_hit_cat: got %h expected %h", dut_vec(), pack(2, 1, 1, 0, 0, 1, 0, 0));
    end
    tick(0, 1, 1, 1, 1);
    checks++;
    if (dut_vec() !== pack(2, 1, 1, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL cd_ignore_inputs: got %h expected %h", dut_vec(), pack(2, 1, 1, 0, 0, 0, 0, 0));
    end
    tick(1, 1, 0, 1, 1);
    checks++;
    if (dut_vec() !== pack(0, 2, 2, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL cd_reset_abort: got %h expected %h", dut_vec(), pack(0, 2, 2, 0, 0, 0, 0, 0));
    end
    tick(0, 1, 0, 0, 0);
  endtask

  task automatic test_draw();
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i < TICKS; i++) tick(0, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== pack(1, 1, 2, 1, 1, 0, 0, 0)) begin
      errors++;
      $display("FAIL draw_setup_a: got %h expected %h", dut_vec(), pack(1, 1, 2, 1, 1, 0, 0, 0));
    end
    tick(0, 0, 0, 0, 1);
    for (int i = 0; i < TICKS; i++) tick(0, 0, 0, 0, 0);
    tick(0, 0, 1, 1, 1);
    checks++;
    if (dut_vec() !== pack(2, 0, 0, 0, 0, 1, 1, 0)) begin
      errors++;
      $display("FAIL draw_double_hit: got %h expected %h", dut_vec(), pack(2, 0, 0, 0, 0, 1, 1, 0));
    end
    for (int i = 0; i < TICKS; i++) tick(0, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== pack(3, 0, 0, 0, 0, 0, 0, 3)) begin
      errors++;
      $display("FAIL draw_over: got %h expected %h", dut_vec(), pack(3, 0, 0, 0, 0, 0, 0, 3));
    end
  endtask

  task automatic test_over_restart();
    tick(0, 0, 1, 1, 1);
    checks++;
    if (dut_vec() !== pack(3, 0, 0, 0, 0, 0, 0, 3)) begin
      errors++;
      $display("FAIL over_ignore: got %h expected %h", dut_vec(), pack(3, 0, 0, 0, 0, 0, 0, 3));
    end
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i < TICKS; i++) tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i < TICKS; i++) tick(0, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== pack(3, 0, 2, 1, 0, 0, 0, 2)) begin
      errors++;
      $display("FAIL over_dog_wins: got %h expected %h", dut_vec(), pack(3, 0, 2, 1, 0, 0, 0, 2));
    end
    tick(0, 1, 0, 0, 0);
    checks++;
    if (dut_vec() !== pack(1, 2, 2, 0, 1, 0, 0, 0)) begin
      errors++;
      $display("FAIL over_restart: got %h expected %h", dut_vec(), pack(1, 2, 2, 0, 1, 0, 0, 0));
    end
  endtask

  task automatic test_random();
    bit r, s, sd, hc, hd;
    logic [15:0] exp_v;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom % 250) == 0;
      s  = ($urandom % 8) == 0;
      sd = ($urandom % 6) == 0;
      hc = ($urandom % 7) == 0;
      hd = ($urandom % 7) == 0;
      tick(r, s, sd, hc, hd);
      exp_v = pack(m_phase, m_hpc, m_hpd, m_turn, (m_phase == 1) ? 1 : 0, m_fc, m_fd, m_win);
      checks++;
      if (dut_vec() !== exp_v) begin
        errors++;
        $display("FAIL random_cycle[%0d]: got %h expected %h", i, dut_vec(), exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit_dog();
    test_shot_done();
    test_cooldown_ignore_and_reset();
    test_draw();
    test_over_restart();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
